// File: rtl/mod_pkg.sv
// Shared definitions for the modular product-of-others datapath.
// Holds the default frame geometry and modulus, the result-buffer state
// encoding, and a conditional-subtract modular adder that other stages
// (e.g. the multiplier's reduction stage) can call directly.
package mod_pkg;

  localparam int N_DEF   = 6;
  localparam int W_DEF   = 9;
  localparam int MOD_DEF = 509;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Add two residues and fold the result back into range with a single
  // conditional subtract. One subtract is enough because both operands are
  // already below MOD, so the sum is below 2*MOD.
  function automatic logic [W_DEF-1:0] mod_add(input logic [W_DEF-1:0] a,
                                               input logic [W_DEF-1:0] b);
    logic [W_DEF:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W_DEF+1)'(MOD_DEF)) s = s - (W_DEF+1)'(MOD_DEF);
    return W_DEF'(s);
  endfunction

endpackage

// File: rtl/mod_red_add.sv
// Combinational modular add: o_sum = (i_a + i_b) folded once by MOD.
// The sum is formed one bit wider than the operands so the carry is never
// lost. With i_b tied to zero the block reduces any W-bit value into
// [0, MOD), which holds because 2*MOD exceeds the largest W-bit value.
// Ports:
//   i_a, i_b : W-bit operands
//   o_sum    : W-bit result after one conditional subtract
module mod_red_add
  import mod_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int MOD = MOD_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  localparam logic [W:0] MOD_W = (W+1)'(MOD);

  logic [W:0] w_sum;
  logic       w_ge;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_ge  = (w_sum >= MOD_W);
  assign o_sum = W'(w_ge ? (w_sum - MOD_W) : w_sum);

endmodule

// File: rtl/mod_result_buffer.sv
// Result buffer behind the modular multiplier. Captures one frame of N
// residues from a stream that cannot be stalled. Each word is reduced into
// [0, MOD) and added into a running modular sum. The frame is then replayed
// over a ready/valid interface, followed by a checksum beat flagged by
// out_last.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid, data_in  : input word strobe and residue (no backpressure)
//   out_valid/out_ready: output handshake
//   data_out, out_last : registered output word; out_last marks the checksum
//   busy               : high while the frame is being replayed
//   ovf_err            : sticky flag, set when an input word had to be dropped
module mod_result_buffer
  import mod_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int MOD = MOD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic         out_last,
  output logic         busy,
  output logic         ovf_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(N - 1);
  localparam logic [CW-1:0] CHK_BEAT  = CW'(N);

  state_t          r_state;
  logic [CW-1:0]   r_wrCnt;
  logic [CW-1:0]   r_rdCnt;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_checksum;
  logic [W-1:0]    r_buf [N];
  logic            r_outValid;
  logic [W-1:0]    r_dataOut;
  logic            r_outLast;
  logic            r_ovfErr;

  logic [W-1:0]    w_xRed;
  logic [W-1:0]    w_accNext;
  logic [CW-1:0]   w_rdNext;

  // Input reduction is the same adder with a zero second operand.
  mod_red_add #(.W(W), .MOD(MOD)) u_inRed (
    .i_a   (data_in),
    .i_b   ('0),
    .o_sum (w_xRed)
  );

  mod_red_add #(.W(W), .MOD(MOD)) u_accAdd (
    .i_a   (r_acc),
    .i_b   (w_xRed),
    .o_sum (w_accNext)
  );

  assign w_rdNext = r_rdCnt + CW'(1);

  // Output beats are preloaded one handshake ahead: on entering DRAIN the
  // first word is already registered, and every accepted beat loads the
  // next word (or the checksum) so data_out never depends on out_ready
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_wrCnt    <= '0;
      r_rdCnt    <= '0;
      r_acc      <= '0;
      r_checksum <= '0;
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_outLast  <= 1'b0;
      r_ovfErr   <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_buf[r_wrCnt] <= w_xRed;
            r_acc          <= w_accNext;
            if (r_wrCnt == LAST_WORD) begin
              r_wrCnt    <= '0;
              r_checksum <= w_accNext;
              r_state    <= DRAIN;
              r_rdCnt    <= '0;
              r_outValid <= 1'b1;
              r_dataOut  <= r_buf[0];
              r_outLast  <= 1'b0;
            end else begin
              r_wrCnt <= r_wrCnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          // The upstream stage cannot wait, so a word arriving now is lost.
          if (in_valid) r_ovfErr <= 1'b1;
          if (r_outValid && out_ready) begin
            if (r_rdCnt == CHK_BEAT) begin
              r_state    <= FILL;
              r_rdCnt    <= '0;
              r_acc      <= '0;
              r_outValid <= 1'b0;
              r_dataOut  <= '0;
              r_outLast  <= 1'b0;
            end else if (r_rdCnt == LAST_WORD) begin
              r_rdCnt   <= CHK_BEAT;
              r_dataOut <= r_checksum;
              r_outLast <= 1'b1;
            end else begin
              r_rdCnt   <= w_rdNext;
              r_dataOut <= r_buf[w_rdNext];
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign data_out  = r_dataOut;
  assign out_last  = r_outLast;
  assign busy      = (r_state == DRAIN);
  assign ovf_err   = r_ovfErr;

endmodule
